// File: rtl/nibble_sum_accum.sv
// nibble_sum_accum: accumulates SAMPLES nibble sums per frame and presents each frame total on valid/ready.
// Optional feature macro: NIBBLE_SUM_ACCUM_SATURATE_EN (clamp instead of wrap on overflow).
module nibble_sum_accum #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned SAMPLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_in_ready, w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0]   r_out_data, w_out_data_nxt;
  logic               r_out_ovf, w_out_ovf_nxt;

  logic [SUM_W-1:0]   w_sum;
  logic               w_sum_ovf;
  logic [ACC_W-1:0]   w_acc_add;
  logic               w_accept;
  logic               w_last;

  // One-bit-wider add exposes the carry used for the sticky overflow flag.
  assign w_sum     = SUM_W'(r_acc) + SUM_W'(in_data);
  assign w_sum_ovf = r_ovf | w_sum[ACC_W];
`ifdef NIBBLE_SUM_ACCUM_SATURATE_EN
  assign w_acc_add = w_sum_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif
  assign w_accept  = in_valid & r_in_ready;
  assign w_last    = (r_cnt == CNT_W'(SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_ovf_nxt   = r_out_ovf;
    if (clr) begin
      w_state_nxt     = ST_ACCUM;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_ovf_nxt       = 1'b0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              w_out_data_nxt  = w_acc_add;
              w_out_ovf_nxt   = w_sum_ovf;
              w_out_valid_nxt = 1'b1;
              w_acc_nxt       = '0;
              w_cnt_nxt       = '0;
              w_ovf_nxt       = 1'b0;
              w_state_nxt     = ST_HOLD;
            end else begin
              w_acc_nxt = w_acc_add;
              w_cnt_nxt = r_cnt + CNT_W'(1);
              w_ovf_nxt = w_sum_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_ACCUM;
          end
        end
        default: w_state_nxt = ST_ACCUM;
      endcase
    end
    // Registered from next state so in_ready never depends combinationally on out_ready.
    w_in_ready_nxt = (w_state_nxt == ST_ACCUM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_nibble_sum_accum.sv
// Bench for nibble_sum_accum: three configurations driven by one stimulus stream, checked against a frame-level model.
module tb_nibble_sum_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;

  logic       rdy0, ov0, of0;
  logic [7:0] od0;
  logic       rdy1, ov1, of1;
  logic [4:0] od1;
  logic       rdy2, ov2, of2;
  logic [7:0] od2;

  int n_vec = 0;
  int n_err = 0;

  // Model state per configuration: 0 = default, 1 = ACC_W 5, 2 = SAMPLES 1
  int m_s[3]  = '{4, 4, 1};
  int m_aw[3] = '{8, 5, 8};
  int m_sum[3], m_n[3], m_pend[3], m_rdy[3], m_data[3], m_ovf[3];

  always #5 clk = ~clk;

  nibble_sum_accum #(.DATA_W(4), .ACC_W(8), .SAMPLES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(of0));

  nibble_sum_accum #(.DATA_W(4), .ACC_W(5), .SAMPLES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(of1));

  nibble_sum_accum #(.DATA_W(4), .ACC_W(8), .SAMPLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ovf(of2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fold(input int sum, input int aw);
    int max;
    max = (1 << aw) - 1;
`ifdef NIBBLE_SUM_ACCUM_SATURATE_EN
    return (sum > max) ? max : sum;
`else
    return sum & max;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_sum[d] = 0; m_n[d] = 0; m_pend[d] = 0;
      m_rdy[d] = 0; m_data[d] = 0; m_ovf[d] = 0;
    end
  endtask

  // Frame-level behaviour: collect accepted samples, emit the folded total once SAMPLES are in.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (clr) begin
        m_pend[d] = 0; m_sum[d] = 0; m_n[d] = 0;
      end else if (m_pend[d] != 0) begin
        if (out_ready) m_pend[d] = 0;
      end else if (in_valid && m_rdy[d] != 0) begin
        m_sum[d] += int'(in_data);
        m_n[d]++;
        if (m_n[d] == m_s[d]) begin
          m_pend[d] = 1;
          m_data[d] = fold(m_sum[d], m_aw[d]);
          m_ovf[d]  = (m_sum[d] > (1 << m_aw[d]) - 1) ? 1 : 0;
          m_sum[d]  = 0;
          m_n[d]    = 0;
        end
      end
      m_rdy[d] = (m_pend[d] == 0) ? 1 : 0;
    end
  endtask

  task automatic check_all();
    chk("rdy0", 32'(rdy0), 32'(m_rdy[0]));
    chk("vld0", 32'(ov0), 32'(m_pend[0]));
    if (m_pend[0] != 0) begin
      chk("dat0", 32'(od0), 32'(m_data[0]));
      chk("ovf0", 32'(of0), 32'(m_ovf[0]));
    end
    chk("rdy1", 32'(rdy1), 32'(m_rdy[1]));
    chk("vld1", 32'(ov1), 32'(m_pend[1]));
    if (m_pend[1] != 0) begin
      chk("dat1", 32'(od1), 32'(m_data[1]));
      chk("ovf1", 32'(of1), 32'(m_ovf[1]));
    end
    chk("rdy2", 32'(rdy2), 32'(m_rdy[2]));
    chk("vld2", 32'(ov2), 32'(m_pend[2]));
    if (m_pend[2] != 0) begin
      chk("dat2", 32'(od2), 32'(m_data[2]));
      chk("ovf2", 32'(of2), 32'(m_ovf[2]));
    end
  endtask

  task automatic cyc(input bit v, input int dat, input bit ordy, input bit c);
    in_valid  = v;
    in_data   = 4'(dat);
    out_ready = ordy;
    clr       = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(rdy0), 32'd0);
    chk("rst_vld", 32'(ov0), 32'd0);
    chk("rst_dat", 32'(od0), 32'd0);
    chk("rst_ovf", 32'(of0), 32'd0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);
    chk("rdy_after_rst", 32'(rdy0), 32'd1);

    // Basic frame
    cyc(1, 1, 1, 0); cyc(1, 2, 1, 0); cyc(1, 3, 1, 0); cyc(1, 4, 1, 0);
    chk("basic_vld", 32'(ov0), 32'd1);
    chk("basic_dat", 32'(od0), 32'd10);
    chk("basic_ovf", 32'(of0), 32'd0);
    cyc(0, 0, 1, 0);
    chk("basic_drop", 32'(ov0), 32'd0);
    chk("basic_rdy", 32'(rdy0), 32'd1);

    // Gaps and backpressure
    cyc(0, 0, 1, 1);
    cyc(1, 5, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 5, 0, 0); cyc(1, 5, 0, 0); cyc(1, 5, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 9, 0, 0);
      chk("bp_dat", 32'(od0), 32'd20);
      chk("bp_rdy", 32'(rdy0), 32'd0);
    end
    cyc(0, 0, 1, 0);
    chk("bp_done", 32'(ov0), 32'd0);

    // Overflow on the 5-bit accumulator
    cyc(0, 0, 1, 1);
    cyc(1, 15, 1, 0); cyc(1, 15, 1, 0); cyc(1, 15, 1, 0); cyc(1, 0, 1, 0);
`ifdef NIBBLE_SUM_ACCUM_SATURATE_EN
    chk("ovf_dat", 32'(od1), 32'd31);
`else
    chk("ovf_dat", 32'(od1), 32'd13);
`endif
    chk("ovf_flag", 32'(of1), 32'd1);
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    chk("ovf_next_dat", 32'(od1), 32'd4);
    chk("ovf_next_flag", 32'(of1), 32'd0);
    cyc(0, 0, 1, 0);

    // Clear mid-frame
    cyc(1, 7, 1, 0); cyc(1, 7, 1, 0); cyc(1, 7, 1, 1);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    chk("clr_dat", 32'(od0), 32'd4);
    cyc(0, 0, 1, 0);

    // Single-sample frames on configuration 2
    cyc(1, 9, 1, 0);
    chk("single_a", 32'(od2), 32'd9);
    chk("single_a_vld", 32'(ov2), 32'd1);
    cyc(0, 0, 1, 0);
    cyc(1, 3, 1, 0);
    chk("single_b", 32'(od2), 32'd3);
    cyc(0, 0, 1, 0);

    // Asynchronous reset while holding a total
    cyc(0, 0, 1, 1);
    cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
    chk("hold_vld", 32'(ov0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(ov0), 32'd0);
    chk("arst_dat", 32'(od0), 32'd0);
    chk("arst_rdy", 32'(rdy0), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0),
          (($urandom_range(0, 1) != 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 15))),
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
